// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory bus arbiter.
package dmem_arb_pkg;

  localparam int ARB_PORTS = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_select2.sv
// Combinational two-way round-robin pick: a lone requester wins,
// a tie goes to the port that was not granted last time.
module rr_select2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the winning port from the request pair and the previous grant.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-port data-memory bus arbiter: latches one request at a time,
// issues a single registered bus strobe, waits out the read latency
// and returns a one-cycle acknowledge to the granted port.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic [BE_W-1:0]   m0_byte_enable,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_read_data,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic [BE_W-1:0]   m1_byte_enable,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_read_data,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_write_data,
  output logic [BE_W-1:0]   bus_byte_enable,
  output logic              bus_read_enable,
  output logic              bus_write_enable,
  input  logic [DATA_W-1:0] bus_read_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  arb_state_e        state_reg, state_next;
  logic              grant_reg;
  logic              write_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] bus_address_reg;
  logic [DATA_W-1:0] bus_write_data_reg;
  logic [BE_W-1:0]   bus_byte_enable_reg;
  logic              bus_read_enable_reg;
  logic              bus_write_enable_reg;
  logic [DATA_W-1:0] read_data_reg [ARB_PORTS];
  logic [ARB_PORTS-1:0] ack_vec;

  logic              grant_valid;
  logic              grant_idx;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_write_data;
  logic [BE_W-1:0]   sel_byte_enable;

  rr_select2 u_rr_select2 (
    .req         ({m1_req, m0_req}),
    .last_grant  (grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_write       = grant_idx ? m1_write       : m0_write;
  assign sel_address     = grant_idx ? m1_address     : m0_address;
  assign sel_write_data  = grant_idx ? m1_write_data  : m0_write_data;
  assign sel_byte_enable = grant_idx ? m1_byte_enable : m0_byte_enable;

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = write_reg ? DONE : WAIT;
      WAIT:    if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, bus drive registers and latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg            <= IDLE;
      grant_reg            <= 1'b1;
      write_reg            <= 1'b0;
      cnt_reg              <= '0;
      bus_address_reg      <= '0;
      bus_write_data_reg   <= '0;
      bus_byte_enable_reg  <= '0;
      bus_read_enable_reg  <= 1'b0;
      bus_write_enable_reg <= 1'b0;
    end else begin
      state_reg            <= state_next;
      bus_read_enable_reg  <= 1'b0;
      bus_write_enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_reg            <= grant_idx;
            write_reg            <= sel_write;
            bus_address_reg      <= sel_address;
            bus_write_data_reg   <= sel_write_data;
            bus_byte_enable_reg  <= sel_byte_enable;
            bus_read_enable_reg  <= ~sel_write;
            bus_write_enable_reg <= sel_write;
          end
        end
        ISSUE: begin
          if (!write_reg) cnt_reg <= CNT_W'(READ_LATENCY - 1);
        end
        WAIT: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < ARB_PORTS; gi++) begin : g_port
    // Capture returning read data for this port when the latency expires.
    always_ff @(posedge clock) begin
      if (reset) begin
        read_data_reg[gi] <= '0;
      end else if (state_reg == WAIT && cnt_reg == '0 && grant_reg == 1'(gi)) begin
        read_data_reg[gi] <= bus_read_data;
      end
    end
    assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
  end

  assign m0_ack           = ack_vec[0];
  assign m1_ack           = ack_vec[1];
  assign m0_read_data     = read_data_reg[0];
  assign m1_read_data     = read_data_reg[1];
  assign bus_address      = bus_address_reg;
  assign bus_write_data   = bus_write_data_reg;
  assign bus_byte_enable  = bus_byte_enable_reg;
  assign bus_read_enable  = bus_read_enable_reg;
  assign bus_write_enable = bus_write_enable_reg;
  assign busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: three instances at read
// latencies 1, 3 and 15; instance 0 (latency 1) carries most scenarios.
module tb_dmem_bus_arbiter;

  localparam int N = 3;

  logic        clock;
  logic        reset;
  logic        m0_req [N];
  logic        m0_write [N];
  logic [31:0] m0_address [N];
  logic [31:0] m0_write_data [N];
  logic [3:0]  m0_byte_enable [N];
  logic        m0_ack [N];
  logic [31:0] m0_read_data [N];
  logic        m1_req [N];
  logic        m1_write [N];
  logic [31:0] m1_address [N];
  logic [31:0] m1_write_data [N];
  logic [3:0]  m1_byte_enable [N];
  logic        m1_ack [N];
  logic [31:0] m1_read_data [N];
  logic [31:0] bus_address [N];
  logic [31:0] bus_write_data [N];
  logic [3:0]  bus_byte_enable [N];
  logic        bus_read_enable [N];
  logic        bus_write_enable [N];
  logic [31:0] bus_read_data [N];
  logic        busy [N];

  int checks;
  int failures;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    dmem_bus_arbiter #(
      .READ_LATENCY((gi == 0) ? 1 : ((gi == 1) ? 3 : 15))
    ) u_dut (
      .clock            (clock),
      .reset            (reset),
      .m0_req           (m0_req[gi]),
      .m0_write         (m0_write[gi]),
      .m0_address       (m0_address[gi]),
      .m0_write_data    (m0_write_data[gi]),
      .m0_byte_enable   (m0_byte_enable[gi]),
      .m0_ack           (m0_ack[gi]),
      .m0_read_data     (m0_read_data[gi]),
      .m1_req           (m1_req[gi]),
      .m1_write         (m1_write[gi]),
      .m1_address       (m1_address[gi]),
      .m1_write_data    (m1_write_data[gi]),
      .m1_byte_enable   (m1_byte_enable[gi]),
      .m1_ack           (m1_ack[gi]),
      .m1_read_data     (m1_read_data[gi]),
      .bus_address      (bus_address[gi]),
      .bus_write_data   (bus_write_data[gi]),
      .bus_byte_enable  (bus_byte_enable[gi]),
      .bus_read_enable  (bus_read_enable[gi]),
      .bus_write_enable (bus_write_enable[gi]),
      .bus_read_data    (bus_read_data[gi]),
      .busy             (busy[gi])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 15);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    for (int k = 0; k < N; k++) begin
      m0_req[k] = 1'b0; m0_write[k] = 1'b0; m0_address[k] = '0;
      m0_write_data[k] = '0; m0_byte_enable[k] = '0;
      m1_req[k] = 1'b0; m1_write[k] = 1'b0; m1_address[k] = '0;
      m1_write_data[k] = '0; m1_byte_enable[k] = '0;
      bus_read_data[k] = 32'hA5A5_A5A5;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({busy[k], m0_ack[k], m1_ack[k], bus_read_enable[k], bus_write_enable[k]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl k=%0d got busy/ack0/ack1/re/we=%b%b%b%b%b want 00000", k,
                 busy[k], m0_ack[k], m1_ack[k], bus_read_enable[k], bus_write_enable[k]);
      end
      checks++;
      if (bus_address[k] !== 32'h0 || bus_write_data[k] !== 32'h0 || bus_byte_enable[k] !== 4'h0) begin
        failures++;
        $display("FAIL reset_bus k=%0d got addr=%h wdata=%h be=%h want zeros", k,
                 bus_address[k], bus_write_data[k], bus_byte_enable[k]);
      end
      checks++;
      if (m0_read_data[k] !== 32'h0 || m1_read_data[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata k=%0d got %h %h want 0 0", k, m0_read_data[k], m1_read_data[k]);
      end
    end
    reset = 1'b0;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_single_write();
    m0_req[0] = 1'b1; m0_write[0] = 1'b1; m0_address[0] = 32'h100;
    m0_write_data[0] = 32'hDEAD_BEEF; m0_byte_enable[0] = 4'hF;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++;
      if (bus_write_enable[0] !== (j == 1) || bus_read_enable[0] !== 1'b0) begin
        failures++;
        $display("FAIL write_strobe cyc=%0d got we=%b re=%b want we=%b re=0", j,
                 bus_write_enable[0], bus_read_enable[0], (j == 1));
      end
      checks++;
      if (m0_ack[0] !== (j == 2) || m1_ack[0] !== 1'b0) begin
        failures++;
        $display("FAIL write_ack cyc=%0d got ack0=%b ack1=%b want ack0=%b ack1=0", j,
                 m0_ack[0], m1_ack[0], (j == 2));
      end
      if (j == 1) begin
        checks++;
        if (bus_address[0] !== 32'h100 || bus_write_data[0] !== 32'hDEAD_BEEF ||
            bus_byte_enable[0] !== 4'hF || busy[0] !== 1'b1) begin
          failures++;
          $display("FAIL write_fields got addr=%h wdata=%h be=%h busy=%b want 00000100 deadbeef f 1",
                   bus_address[0], bus_write_data[0], bus_byte_enable[0], busy[0]);
        end
      end
      if (j == 3) m0_req[0] = 1'b0;
    end
    m0_write[0] = 1'b0;
    $display("txn single write m0 addr=00000100 data=deadbeef");
  endtask

  task automatic test_latency();
    for (int k = 0; k < N; k++) begin
      int lat;
      lat = lat_of(k);
      m1_req[k] = 1'b1; m1_write[k] = 1'b0; m1_address[k] = 32'h200 + 32'(k);
      m1_byte_enable[k] = 4'h3;
      for (int j = 1; j <= lat + 5; j++) begin
        tick();
        bus_read_data[k] = (j == 1 + lat) ? 32'h1234_5678 : 32'hA5A5_A5A5;
        if (j == 1) begin
          checks++;
          if (bus_read_enable[k] !== 1'b1 || bus_address[k] !== 32'h200 + 32'(k)) begin
            failures++;
            $display("FAIL lat_issue L=%0d got re=%b addr=%h want 1 %h", lat,
                     bus_read_enable[k], bus_address[k], 32'h200 + 32'(k));
          end
        end
        checks++;
        if (m1_ack[k] !== (j == 2 + lat) || m0_ack[k] !== 1'b0) begin
          failures++;
          $display("FAIL lat_ack L=%0d cyc=%0d got ack1=%b ack0=%b want ack1=%b ack0=0", lat, j,
                   m1_ack[k], m0_ack[k], (j == 2 + lat));
        end
        if (j >= 2 + lat) begin
          checks++;
          if (m1_read_data[k] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL lat_rdata L=%0d cyc=%0d got %h want 12345678", lat, j, m1_read_data[k]);
          end
        end
        if (j == 3 + lat) m1_req[k] = 1'b0;
      end
      $display("txn read m1 latency=%0d data=%h", lat, m1_read_data[k]);
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    m0_req[0] = 1'b1; m0_write[0] = 1'b0; m0_address[0] = 32'h400;
    m1_req[0] = 1'b1; m1_write[0] = 1'b0; m1_address[0] = 32'h500;
    tick();
    reset = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      logic exp0, exp1;
      tick();
      bus_read_data[0] = 32'h1000_0000 + 32'(j);
      exp0 = (j % 4 == 3) && ((j / 4) % 2 == 0);
      exp1 = (j % 4 == 3) && ((j / 4) % 2 == 1);
      checks++;
      if (m0_ack[0] !== exp0 || m1_ack[0] !== exp1) begin
        failures++;
        $display("FAIL contention_ack cyc=%0d got ack0=%b ack1=%b want %b %b", j,
                 m0_ack[0], m1_ack[0], exp0, exp1);
      end
      if (exp0 || exp1) begin
        checks++;
        if ((exp0 ? m0_read_data[0] : m1_read_data[0]) !== 32'h1000_0000 + 32'(j - 1)) begin
          failures++;
          $display("FAIL contention_rdata cyc=%0d got %h want %h", j,
                   exp0 ? m0_read_data[0] : m1_read_data[0], 32'h1000_0000 + 32'(j - 1));
        end
        $display("txn contention ack port=%0d cyc=%0d", exp1 ? 1 : 0, j);
      end
      if (j == 20) begin
        m0_req[0] = 1'b0;
        m1_req[0] = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    m0_req[0] = 1'b1; m0_write[0] = 1'b0; m0_address[0] = 32'h600;
    tick();
    tick();
    reset = 1'b1;
    m0_req[0] = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || bus_read_enable[0] !== 1'b0 || bus_write_enable[0] !== 1'b0 ||
        bus_address[0] !== 32'h0 || bus_write_data[0] !== 32'h0 || bus_byte_enable[0] !== 4'h0) begin
      failures++;
      $display("FAIL rst_wait_bus got busy=%b re=%b we=%b addr=%h wd=%h be=%h want all 0",
               busy[0], bus_read_enable[0], bus_write_enable[0], bus_address[0],
               bus_write_data[0], bus_byte_enable[0]);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (m0_ack[0] !== 1'b0 || m1_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL rst_wait_quiet cyc=%0d got ack0=%b ack1=%b busy=%b want 0 0 0", j,
                 m0_ack[0], m1_ack[0], busy[0]);
      end
      tick();
    end
    m0_req[0] = 1'b1; m0_address[0] = 32'h700;
    bus_read_data[0] = 32'h0BAD_F00D;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++;
      if (m0_ack[0] !== (j == 3)) begin
        failures++;
        $display("FAIL rst_wait_fresh_ack cyc=%0d got %b want %b", j, m0_ack[0], (j == 3));
      end
      if (j == 3) begin
        checks++;
        if (m0_read_data[0] !== 32'h0BAD_F00D) begin
          failures++;
          $display("FAIL rst_wait_fresh_rdata got %h want 0badf00d", m0_read_data[0]);
        end
      end
      if (j == 4) m0_req[0] = 1'b0;
    end
    $display("txn reset-in-wait then fresh read m0 data=%h", m0_read_data[0]);
  endtask

  task automatic test_early_drop();
    int strobes;
    strobes = 0;
    m0_req[0] = 1'b1; m0_write[0] = 1'b0; m0_address[0] = 32'h800;
    bus_read_data[0] = 32'hCAFE_0001;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (bus_read_enable[0] === 1'b1 || bus_write_enable[0] === 1'b1) strobes++;
      if (j == 1) m0_req[0] = 1'b0;
      checks++;
      if (m0_ack[0] !== (j == 3) || m1_ack[0] !== 1'b0) begin
        failures++;
        $display("FAIL early_drop_ack cyc=%0d got ack0=%b ack1=%b want %b 0", j,
                 m0_ack[0], m1_ack[0], (j == 3));
      end
    end
    checks++;
    if (strobes != 1) begin
      failures++;
      $display("FAIL early_drop_strobes got %0d want 1", strobes);
    end
    $display("txn early drop m0 read data=%h strobes=%0d", m0_read_data[0], strobes);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    init_inputs();
    test_reset();
    test_single_write();
    test_latency();
    test_contention();
    test_reset_in_wait();
    test_early_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
